// File: rtl/reg_scoreboard.sv
// ============================================================================
// Module   : reg_scoreboard
// Brief    : Per-register pending-write scoreboard that raises issue stall on hazards.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_scoreboard #(
    parameter int MAX_PEND = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_issue_vld,
    input  logic        i_issue_wr,
    input  logic [3:0]  i_issue_dst,
    input  logic [3:0]  i_src1,
    input  logic [3:0]  i_src2,
    input  logic        i_src1_used,
    input  logic        i_src2_used,
    input  logic        i_wb_vld,
    input  logic [3:0]  i_wb_dst,
    input  logic        i_flush,
    output logic        o_stall,
    output logic [15:0] o_pending,
    output logic        o_err
);

    localparam logic [1:0] c_MAX_PEND = MAX_PEND[1:0];

    logic [1:0] r_cnt     [16];
    logic [1:0] w_cnt_nxt [16];
    logic       r_err;

    logic       w_src1_haz;
    logic       w_src2_haz;
    logic       w_dst_full;
    logic       w_wb_live;
    logic       w_inc;
    logic       w_dec;
    logic       w_err_set;

    // A retiring write to a source whose count is exactly one clears the hazard this cycle.
    always_comb begin
        w_src1_haz = i_src1_used && (i_src1 != 4'd0) && (r_cnt[i_src1] != 2'd0)
                     && !((r_cnt[i_src1] == 2'd1) && i_wb_vld && (i_wb_dst == i_src1));
        w_src2_haz = i_src2_used && (i_src2 != 4'd0) && (r_cnt[i_src2] != 2'd0)
                     && !((r_cnt[i_src2] == 2'd1) && i_wb_vld && (i_wb_dst == i_src2));
        w_dst_full = i_issue_wr && (i_issue_dst != 4'd0) && (r_cnt[i_issue_dst] == c_MAX_PEND);
    end

    assign o_stall   = i_issue_vld && (w_src1_haz || w_src2_haz || w_dst_full);
    assign w_wb_live = i_wb_vld && (i_wb_dst != 4'd0);
    assign w_inc     = i_issue_vld && !o_stall && i_issue_wr && (i_issue_dst != 4'd0);
    assign w_dec     = w_wb_live && (r_cnt[i_wb_dst] != 2'd0);
    assign w_err_set = w_wb_live && (r_cnt[i_wb_dst] == 2'd0);

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (i == 0 || i_flush) begin
                w_cnt_nxt[i] = 2'd0;
            end else if (w_inc && (i_issue_dst == 4'(i)) && !(w_dec && (i_wb_dst == 4'(i)))) begin
                w_cnt_nxt[i] = r_cnt[i] + 2'd1;
            end else if (w_dec && (i_wb_dst == 4'(i)) && !(w_inc && (i_issue_dst == 4'(i)))) begin
                w_cnt_nxt[i] = r_cnt[i] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_cnt[i] <= 2'd0;
            end
            r_err <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_pending[0] = 1'b0;

    generate
        for (genvar g = 1; g < 16; g++) begin : g_pend
            assign o_pending[g] = (r_cnt[g] != 2'd0);
        end
    endgenerate

    assign o_err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
// ============================================================================
// Module   : tb_reg_scoreboard
// Brief    : Table-driven self-checking bench for reg_scoreboard with result queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_reg_scoreboard;

    logic        clk;
    logic        rst;
    logic        issue_vld;
    logic        issue_wr;
    logic [3:0]  issue_dst;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        src1_used;
    logic        src2_used;
    logic        wb_vld;
    logic [3:0]  wb_dst;
    logic        flush;
    logic        stall;
    logic [15:0] pending;
    logic        err;

    int tests;
    int fails;

    typedef struct {
        logic        vld;
        logic        wr;
        logic [3:0]  dst;
        logic [3:0]  s1;
        logic        u1;
        logic [3:0]  s2;
        logic        u2;
        logic        wbv;
        logic [3:0]  wbd;
        logic        fl;
        logic        exp_stall;
        logic [15:0] exp_pend;
        logic        exp_err;
    } vec_t;

    vec_t        tbl [28];
    logic [16:0] sb_q [$];

    reg_scoreboard #(.MAX_PEND(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_issue_vld (issue_vld),
        .i_issue_wr  (issue_wr),
        .i_issue_dst (issue_dst),
        .i_src1      (src1),
        .i_src2      (src2),
        .i_src1_used (src1_used),
        .i_src2_used (src2_used),
        .i_wb_vld    (wb_vld),
        .i_wb_dst    (wb_dst),
        .i_flush     (flush),
        .o_stall     (stall),
        .o_pending   (pending),
        .o_err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic vld, input logic wr, input logic [3:0] dst,
                                input logic [3:0] s1, input logic u1,
                                input logic [3:0] s2, input logic u2,
                                input logic wbv, input logic [3:0] wbd, input logic fl,
                                input logic es, input logic [15:0] ep, input logic ee);
        vec_t v;
        v.vld = vld; v.wr = wr; v.dst = dst; v.s1 = s1; v.u1 = u1;
        v.s2 = s2; v.u2 = u2; v.wbv = wbv; v.wbd = wbd; v.fl = fl;
        v.exp_stall = es; v.exp_pend = ep; v.exp_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        issue_vld = 0; issue_wr = 0; issue_dst = 0; src1 = 0; src2 = 0;
        src1_used = 0; src2_used = 0; wb_vld = 0; wb_dst = 0; flush = 0;
    endtask

    // Drive one vector mid-cycle, check combinational stall, then compare registered outputs.
    task automatic apply(input vec_t v, input int idx);
        logic [16:0] e;
        @(negedge clk);
        issue_vld = v.vld; issue_wr = v.wr; issue_dst = v.dst;
        src1 = v.s1; src1_used = v.u1; src2 = v.s2; src2_used = v.u2;
        wb_vld = v.wbv; wb_dst = v.wbd; flush = v.fl;
        #1;
        check($sformatf("stall[v%0d]", idx), {31'd0, stall}, {31'd0, v.exp_stall});
        sb_q.push_back({v.exp_err, v.exp_pend});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL queue[v%0d]: got empty expected entry", idx);
        end else begin
            e = sb_q.pop_front();
            check($sformatf("pending[v%0d]", idx), {16'd0, pending}, {16'd0, e[15:0]});
            check($sformatf("err[v%0d]", idx), {31'd0, err}, {31'd0, e[16]});
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        drive_idle();
        rst = 1'b1;

        //            vld wr dst s1 u1 s2 u2 wbv wbd fl  stall pend     err
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
        tbl[1]  = mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0008, 0);
        tbl[2]  = mk(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 1, 16'h0008, 0);
        tbl[3]  = mk(1, 0, 0, 3, 1, 0, 0, 1, 3, 0, 0, 16'h0000, 0);
        tbl[4]  = mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0020, 0);
        tbl[5]  = mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0020, 0);
        tbl[6]  = mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0020, 0);
        tbl[7]  = mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0020, 0);
        tbl[8]  = mk(1, 1, 5, 0, 0, 0, 0, 1, 5, 0, 1, 16'h0020, 0);
        tbl[9]  = mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0020, 0);
        tbl[10] = mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0020, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 16'h0020, 0);
        tbl[12] = mk(1, 0, 0, 5, 1, 0, 0, 1, 5, 0, 1, 16'h0020, 0);
        tbl[13] = mk(1, 0, 0, 0, 0, 5, 1, 1, 5, 0, 0, 16'h0000, 0);
        tbl[14] = mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0080, 0);
        tbl[15] = mk(1, 1, 7, 0, 0, 0, 0, 1, 7, 0, 0, 16'h0080, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 16'h0000, 0);
        tbl[17] = mk(1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 16'h0000, 0);
        tbl[18] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0002, 0);
        tbl[19] = mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 16'h0002, 0);
        tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 16'h0000, 0);
        tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 16'h0000, 1);
        tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 1);
        tbl[23] = mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0004, 1);
        tbl[24] = mk(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0014, 1);
        tbl[25] = mk(1, 1, 6, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 1);
        tbl[26] = mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0004, 1);
        tbl[27] = mk(1, 0, 0, 2, 1, 0, 0, 0, 0, 1, 1, 16'h0000, 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_pending", {16'd0, pending}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);

        for (int i = 0; i < 28; i++) begin
            apply(tbl[i], i);
        end

        // Asynchronous reset between edges must clear tracking and the sticky error at once.
        apply(mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0004, 1), 100);
        apply(mk(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0014, 1), 101);
        @(negedge clk);
        drive_idle();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_pending", {16'd0, pending}, 32'd0);
        check("async_rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        apply(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0008, 0), 102);
        apply(mk(1, 0, 0, 4, 1, 2, 1, 0, 0, 0, 0, 16'h0008, 0), 103);

        if (sb_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL queue_drain: got %0d entries expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter: MAX_PEND, default 3, meaning max in-flight writes tracked per register (1..3; per-register counter is 2 bits).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 issue_vld  input  1  decode stage presents an instruction this cycle.
REQ-005 issue_wr  input  1  presented instruction writes a register (RegWrite).
REQ-006 issue_dst  input  4  destination register of presented instruction (output of destination-select mux).
REQ-007 src1, src2  input  4 each  source register numbers read by presented instruction.
REQ-008 src1_used, src2_used  input  1 each  corresponding source is actually read.
REQ-009 wb_vld  input  1  writeback stage retires a register write this cycle.
REQ-010 wb_dst  input  4  register written by retiring instruction.
REQ-011 flush  input  1  squash all in-flight instructions.
REQ-012 stall  output  1  presented instruction shall not issue this cycle.
REQ-013 pending  output  16  bit n = 1 when register n has count > 0.
REQ-014 err  output  1  sticky: writeback seen for a register with count 0.

Function
REQ-015 Each register R1..R15 SHALL have a 2-bit pending counter; R0 is hardwired zero: never pending, issue/wb to R0 ignored, src of R0 never stalls.
REQ-016 stall SHALL be combinational: issue_vld AND (src hazard OR dst full).
REQ-017 Src hazard: srcN_used AND cnt[srcN] != 0, except no hazard when cnt[srcN] == 1 AND wb_vld AND wb_dst == srcN (same-cycle retirement bypass).
REQ-018 Dst full: issue_wr AND issue_dst != 0 AND cnt[issue_dst] == MAX_PEND (a same-cycle writeback to issue_dst does not relieve full).
REQ-019 Issue accepted when issue_vld AND NOT stall; accepted with issue_wr and issue_dst != 0 SHALL increment cnt[issue_dst] at next edge.
REQ-020 wb_vld with wb_dst != 0 and cnt[wb_dst] != 0 SHALL decrement cnt[wb_dst] at next edge.
REQ-021 Increment and decrement to same register in same cycle SHALL leave count unchanged.
REQ-022 wb_vld with wb_dst != 0 and cnt[wb_dst] == 0: counter stays 0 (no wrap), err set to 1 at next edge.
REQ-023 Counters SHALL never wrap above MAX_PEND or below 0.
REQ-024 flush SHALL clear all counters at next edge, overriding same-cycle issue and wb; flush does not clear err; stall remains computed from current counts.
REQ-025 pending SHALL reflect registered counters only (no combinational path from inputs); pending[0] always 0.
REQ-026 Latency: counter update visible on pending/stall one cycle after the accepting edge.

Reset
REQ-027 rst high SHALL asynchronously clear all counters and err; pending = 0, stall = 0 absent issue_vld with a full dst (none possible after reset).
REQ-028 rst asserted mid-operation discards all in-flight tracking; first edge after deassertion behaves as from power-up.

Verification
REQ-029 Issue wr R3 (src unused), next cycle issue src1=R3 -> pending=0x0008, stall=1; wb R3 -> same cycle stall=0, next cycle pending=0.
REQ-030 Issue wr R5 three times, fourth issue wr R5 -> stall=1, cnt stays 3; simultaneous wb R5 with fourth issue -> still stall=1, cnt 2 after edge.
REQ-031 cnt[R7]=1, same-cycle accepted issue wr R7 and wb R7 -> pending[7] stays 1, cnt 1.
REQ-032 wb R9 with cnt 0 -> err=1 next cycle, pending=0; err persists through flush, cleared only by rst.
REQ-033 Issue wr R0 and src1=R0 with wb R0 -> stall=0, pending=0, err=0.
REQ-034 R2,R4 pending; flush with simultaneous issue wr R6 -> pending=0 next cycle; rst asserted between edges -> pending=0 immediately.
